// File: rtl/ila_pkg.sv
// rtl/ila_pkg.sv - shared capture states, limits and trigger compare for the ILA capture stage
package ila_pkg;

  localparam int ILA_MIN_DEPTH   = 4;
  // Widest probe bus the trigger helper accepts; narrower buses are zero-extended.
  localparam int ILA_MAX_PROBE_W = 1024;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT,
    POST,
    READ
  } cap_state_t;

  // Zero-extending all three operands is harmless: the extended mask bits are 0.
  function automatic logic trig_match(
    input logic [ILA_MAX_PROBE_W-1:0] sample,
    input logic [ILA_MAX_PROBE_W-1:0] value,
    input logic [ILA_MAX_PROBE_W-1:0] mask
  );
    return ((sample ^ value) & mask) == '0;
  endfunction

endpackage

// File: rtl/ila_capture_ram.sv
// rtl/ila_capture_ram.sv - simple dual-port sample buffer with registered read
// Ports:
//   clk      clock
//   wr_en    write strobe, wr_addr/wr_data written on the edge
//   rd_en    read strobe, rd_data holds mem[rd_addr] from the following cycle
module ila_capture_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ila_capture.sv
// rtl/ila_capture.sv - triggered circular-buffer probe capture with streamed readout
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   probe_in                   sample written every capture cycle
//   trig_mask, trig_value      masked-compare trigger
//   pretrig_len                samples kept ahead of the trigger sample
//   arm, abort                 start / cancel pulses
//   busy, triggered, done      status
//   rd_data, rd_valid, rd_ready, rd_last   readout stream
module ila_capture
  import ila_pkg::*;
#(
  parameter  int PROBE_W = 32,
  parameter  int DEPTH   = 256,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PROBE_W-1:0] probe_in,
  input  logic [PROBE_W-1:0] trig_mask,
  input  logic [PROBE_W-1:0] trig_value,
  input  logic [ADDR_W-1:0]  pretrig_len,
  input  logic               arm,
  input  logic               abort,
  output logic               busy,
  output logic               triggered,
  output logic               done,
  output logic [PROBE_W-1:0] rd_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic               rd_last
);

  if (DEPTH < ILA_MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ila_capture: DEPTH must be a power of 2 and at least ILA_MIN_DEPTH");
  end
  if (PROBE_W > ILA_MAX_PROBE_W) begin : g_bad_width
    $error("ila_capture: PROBE_W exceeds ILA_MAX_PROBE_W");
  end

  cap_state_t state, next_state;

  logic [ADDR_W-1:0]  plen;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  fill;
  logic [ADDR_W-1:0]  post;
  logic [ADDR_W-1:0]  post_init;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W:0]    rd_issued;

  logic               hit;
  logic               wr_en;
  logic               rd_issue;
  logic               pop;
  logic [1:0]         occ;

  logic [PROBE_W-1:0] ram_q;
  logic               ram_vld;
  logic               ram_last;
  logic [PROBE_W-1:0] out_data;
  logic               out_vld;
  logic               out_last;
  logic [PROBE_W-1:0] skid_data;
  logic               skid_vld;
  logic               skid_last;

  assign hit = trig_match(ILA_MAX_PROBE_W'(probe_in),
                          ILA_MAX_PROBE_W'(trig_value),
                          ILA_MAX_PROBE_W'(trig_mask));

  assign post_init = ADDR_W'(DEPTH - 1) - plen;
  assign pop       = out_vld & rd_ready;

  // Samples already owed to the output side after this cycle's pop; a read
  // may only be issued when its data is guaranteed a slot (output or skid).
  assign occ = 2'(out_vld) + 2'(skid_vld) + 2'(ram_vld) - 2'(pop);

  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    rd_issue   = 1'b0;
    case (state)
      IDLE: begin
        if (arm) begin
          next_state = (pretrig_len != '0) ? PRE : WAIT;
        end
      end
      PRE: begin
        wr_en = 1'b1;
        if (fill + ADDR_W'(1) == plen) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        wr_en = 1'b1;
        if (hit) begin
          next_state = (post_init == '0) ? READ : POST;
        end
      end
      POST: begin
        wr_en = 1'b1;
        if (post == ADDR_W'(1)) begin
          next_state = READ;
        end
      end
      READ: begin
        rd_issue = !rd_issued[ADDR_W] && (occ < 2'd2);
        if (pop && out_last) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (abort) begin
      next_state = IDLE;
      rd_issue   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plen      <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      post      <= '0;
      rd_ptr    <= '0;
      rd_issued <= '0;
      triggered <= 1'b0;
      done      <= 1'b0;
      ram_vld   <= 1'b0;
      ram_last  <= 1'b0;
      out_data  <= '0;
      out_vld   <= 1'b0;
      out_last  <= 1'b0;
      skid_data <= '0;
      skid_vld  <= 1'b0;
      skid_last <= 1'b0;
    end else if (abort) begin
      done      <= 1'b0;
      triggered <= 1'b0;
      ram_vld   <= 1'b0;
      ram_last  <= 1'b0;
      out_vld   <= 1'b0;
      out_last  <= 1'b0;
      skid_vld  <= 1'b0;
      skid_last <= 1'b0;
    end else begin
      done    <= 1'b0;
      ram_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            plen      <= pretrig_len;
            wr_ptr    <= '0;
            fill      <= '0;
            rd_issued <= '0;
          end
        end
        PRE: begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          fill   <= fill + ADDR_W'(1);
        end
        WAIT: begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          if (hit) begin
            triggered <= 1'b1;
            post      <= post_init;
            // Oldest kept sample sits plen slots behind the trigger, modulo DEPTH.
            rd_ptr    <= wr_ptr - plen;
            rd_issued <= '0;
          end
        end
        POST: begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          post   <= post - ADDR_W'(1);
        end
        READ: begin
          if (rd_issue) begin
            rd_ptr    <= rd_ptr + ADDR_W'(1);
            rd_issued <= rd_issued + (ADDR_W+1)'(1);
          end
          ram_vld  <= rd_issue;
          ram_last <= rd_issue && (rd_issued == (ADDR_W+1)'(DEPTH - 1));

          // Output register refills from the skid first to keep order.
          if (!out_vld || pop) begin
            if (skid_vld) begin
              out_vld   <= 1'b1;
              out_data  <= skid_data;
              out_last  <= skid_last;
              skid_vld  <= ram_vld;
              skid_data <= ram_q;
              skid_last <= ram_last;
            end else if (ram_vld) begin
              out_vld  <= 1'b1;
              out_data <= ram_q;
              out_last <= ram_last;
            end else begin
              out_vld  <= 1'b0;
              out_last <= 1'b0;
            end
          end else if (ram_vld) begin
            skid_vld  <= 1'b1;
            skid_data <= ram_q;
            skid_last <= ram_last;
          end

          if (pop && out_last) begin
            done      <= 1'b1;
            triggered <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  ila_capture_ram #(
    .DATA_W (PROBE_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (probe_in),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  assign busy     = (state != IDLE);
  assign rd_valid = out_vld;
  assign rd_data  = out_data;
  assign rd_last  = out_last;

endmodule

// File: doc/ila_capture.md
Name: ila_capture

Overview:
- In-fabric capture stage that sits directly downstream of the `FPGA_ILA` probe-wire block.
- Consumes the same kept probe bus and stores a DEPTH-sample window around a masked-compare trigger in a circular buffer.
- Drains the window as a valid/ready stream to the debug readout path (UART/JTAG bridge).
- Lets the team capture probe data on targets where the vendor ILA core is unavailable.

Parameters:
- PROBE_W, 32: width of the probe bus and of each stored sample.
- DEPTH, 256: samples per capture window; must be a power of 2, minimum 4.
- ADDR_W, $clog2(DEPTH): buffer address width (derived; not overridden).

Ports:
- clk  in  1  capture/readout clock; the same clock that drives the probes.
- rst_n  in  1  asynchronous active-low reset.
- probe_in  in  PROBE_W  probe sample; written every cycle while capturing.
- trig_mask  in  PROBE_W  1 = bit participates in the trigger compare.
- trig_value  in  PROBE_W  compare value.
- pretrig_len  in  ADDR_W  samples to keep before the trigger sample.
- arm  in  1  single-cycle start pulse.
- abort  in  1  single-cycle cancel pulse.
- busy  out  1  high in any state other than IDLE.
- triggered  out  1  high from the trigger cycle until return to IDLE.
- done  out  1  one-cycle pulse after the last readout handshake.
- rd_data  out  PROBE_W  readout sample.
- rd_valid  out  1  readout valid.
- rd_ready  in  1  readout ready.
- rd_last  out  1  marks the final (DEPTH-th) sample, qualified by rd_valid.

Behaviour:
- Reset (async assert, sync deassert, handled externally): state=IDLE; busy, triggered, done, rd_valid, rd_last = 0; rd_data = 0; all pointers and counters = 0. Buffer contents are undefined.
- Trigger match: ((probe_in ^ trig_value) & trig_mask) == 0. trig_mask = 0 triggers on the first eligible cycle.
- IDLE:
  - arm=1 latches pretrig_len into plen, sets wr_ptr=0 and fill=0.
  - Goes to PRE if plen>0, else to WAIT.
  - arm is ignored in every other state.
- PRE:
  - Writes probe_in to buf[wr_ptr] each cycle, wr_ptr++, fill++.
  - Trigger matches are ignored.
  - When fill == plen, goes to WAIT on the following cycle.
- WAIT:
  - Writes each cycle; wr_ptr wraps modulo DEPTH.
  - On the first cycle with a match, that sample is written, trig_addr=wr_ptr, triggered=1, post=DEPTH-plen-1, go to POST.
  - If post==0, go straight to READ.
- POST:
  - Writes each cycle, post-- per write.
  - After the write that takes post to 0, goes to READ.
  - The window then holds exactly plen pre-trigger samples, the trigger sample, and DEPTH-plen-1 post-trigger samples.
- READ:
  - rd_ptr starts at (trig_addr - plen) mod DEPTH.
  - Synchronous 1-cycle RAM feeding a 1-entry output register plus a 1-entry skid.
  - First rd_valid appears 2 cycles after READ entry.
  - Sustains 1 sample/cycle with rd_ready held high.
  - While rd_valid && !rd_ready, rd_data and rd_last stay stable.
  - Exactly DEPTH samples are sent, in chronological order, with no drop or duplicate.
  - rd_last=1 on the DEPTH-th sample.
  - After the handshake of that sample: done=1 for one cycle, state=IDLE, triggered=0.
- Probe writes occur only in PRE, WAIT and POST.
- abort, in any state: next cycle state=IDLE; rd_valid, rd_last, triggered = 0. No done pulse.
- abort has priority over a simultaneous arm, trigger or handshake.
- Reset mid-capture or mid-readout: immediate return to reset values. No partial readout resumes.
- Wrap-around: the write pointer wraps freely in WAIT. Readout address arithmetic is modulo DEPTH, unsigned, ADDR_W bits.

Decomposition:
- Shared package ila_pkg:
  - cap_state_t enum: IDLE, PRE, WAIT, POST, READ.
  - Function trig_match(sample, value, mask).
  - Constant ILA_MIN_DEPTH = 4.
- One sub-module, ila_capture_ram:
  - Simple dual-port RAM, one write port, one registered read port, DEPTH x PROBE_W.
  - Written in inferable form with no reset on the array.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> all outputs 0 asynchronously; after release busy=0, rd_valid=0.
- Basic window (DEPTH=16, PROBE_W=8): probe counts 0x00,0x01,... per cycle from arm; pretrig_len=4, mask=0xFF, value=0x20 -> 16 samples 0x1C..0x2B, rd_last on 0x2B, done one cycle after.
- Zero pretrigger: pretrig_len=0, value=0x05 -> first sample 0x05, last 0x14; PRE never entered.
- Trigger ignored in PRE: pretrig_len=8, value=0x02 on an 8-bit counter -> 0x02 is not accepted; capture triggers on 0x102 wrap, i.e. counter value 0x02 on the next lap; first sample equals that trigger sample minus 8.
- Backpressure: rd_ready pseudo-random 50% during READ -> 16 unique in-order samples; rd_data stable whenever rd_valid && !rd_ready.
- Abort/reset mid-run: abort during POST -> IDLE next cycle, no rd_valid, no done; re-arm produces a correct window. rst_n low during READ -> outputs 0; subsequent arm works.
